// File: rtl/egol_board_defs.sv
// Shared EGO1 board constants: 7-segment patterns (active-high, seg[0]=a),
// one-hot digit enables and the default digit scan divider for a 100 MHz clock.
package egol_board_defs;

  localparam logic [7:0] SEG_0     = 8'h3F;
  localparam logic [7:0] SEG_1     = 8'h06;
  localparam logic [7:0] SEG_2     = 8'h5B;
  localparam logic [7:0] SEG_3     = 8'h4F;
  localparam logic [7:0] SEG_4     = 8'h66;
  localparam logic [7:0] SEG_5     = 8'h6D;
  localparam logic [7:0] SEG_6     = 8'h7D;
  localparam logic [7:0] SEG_7     = 8'h07;
  localparam logic [7:0] SEG_8     = 8'h7F;
  localparam logic [7:0] SEG_9     = 8'h6F;
  localparam logic [7:0] SEG_BLANK = 8'h00;

  localparam logic [3:0] AN_DIG0 = 4'b0001;
  localparam logic [3:0] AN_DIG1 = 4'b0010;
  localparam logic [3:0] AN_DIG2 = 4'b0100;
  localparam logic [3:0] AN_DIG3 = 4'b1000;

  // 1 ms per digit slot at 100 MHz
  localparam int SCAN_DIV_DEFAULT = 100000;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to 7-segment decoder shared by the EGO1 examples.
// Values above 9 decode to a blank digit.
module seg7_decode
  import egol_board_defs::*;
(
  input  logic [3:0] bcd,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/z_event_display.sv
// Counts rising edges of the upstream Z output in BCD, keeps a history of y
// transitions on the LEDs and scans count/y onto the 4-digit display.
module z_event_display
  import egol_board_defs::*;
#(
  parameter int SCAN_DIV = SCAN_DIV_DEFAULT,
  parameter int HIST_LEN = 8
) (
  input  logic                CP,
  input  logic                rst,
  input  logic                y,
  input  logic                Z,
  input  logic                clr_cnt,
  output logic [7:0]          cnt_bcd,
  output logic [HIST_LEN-1:0] led,
  output logic [3:0]          an,
  output logic [7:0]          seg
);

  localparam int SCAN_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  logic              y_meta, y_s, y_d;
  logic              z_meta, z_s, z_d;
  logic              z_rise;
  logic [3:0]        ones, tens;
  logic [SCAN_W-1:0] scan_cnt;
  logic [1:0]        dig_idx;
  logic [3:0]        dig_val;
  logic [3:0]        an_next;
  logic [7:0]        seg_next;

  // y and Z are asynchronous to CP, so both get a two-flop synchroniser
  always_ff @(posedge CP) begin
    if (rst) begin
      y_meta <= 1'b0;
      y_s    <= 1'b0;
      y_d    <= 1'b0;
      z_meta <= 1'b0;
      z_s    <= 1'b0;
      z_d    <= 1'b0;
    end else begin
      y_meta <= y;
      y_s    <= y_meta;
      y_d    <= y_s;
      z_meta <= Z;
      z_s    <= z_meta;
      z_d    <= z_s;
    end
  end

  assign z_rise = z_s & ~z_d;

  // clr_cnt wins over a coincident edge; 99 wraps silently to 00
  always_ff @(posedge CP) begin
    if (rst || clr_cnt) begin
      ones <= 4'd0;
      tens <= 4'd0;
    end else if (z_rise) begin
      if (ones == 4'd9) begin
        ones <= 4'd0;
        tens <= (tens == 4'd9) ? 4'd0 : tens + 4'd1;
      end else begin
        ones <= ones + 4'd1;
      end
    end
  end

  assign cnt_bcd = {tens, ones};

  always_ff @(posedge CP) begin
    if (rst) begin
      led <= '0;
    end else if (y_s != y_d) begin
      led <= {led[HIST_LEN-2:0], y_s};
    end
  end

  always_ff @(posedge CP) begin
    if (rst) begin
      scan_cnt <= '0;
      dig_idx  <= 2'd0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      dig_idx  <= dig_idx + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // Slot 3 feeds a non-BCD code so the shared decoder blanks it
  always_comb begin
    an_next = AN_DIG0;
    dig_val = ones;
    case (dig_idx)
      2'd0: begin an_next = AN_DIG0; dig_val = ones;            end
      2'd1: begin an_next = AN_DIG1; dig_val = tens;            end
      2'd2: begin an_next = AN_DIG2; dig_val = {3'b000, y_s};   end
      2'd3: begin an_next = AN_DIG3; dig_val = 4'hF;            end
      default: begin an_next = AN_DIG0; dig_val = ones;         end
    endcase
  end

  seg7_decode u_decode (
    .bcd (dig_val),
    .seg (seg_next)
  );

  always_ff @(posedge CP) begin
    if (rst) begin
      an  <= AN_DIG0;
      seg <= SEG_0;
    end else begin
      an  <= an_next;
      seg <= seg_next;
    end
  end

endmodule

// File: tb/tb_z_event_display.sv
// Directed self-checking bench for z_event_display with a shortened scan divider.
module tb_z_event_display;

  logic       CP = 1'b0;
  logic       rst, y, Z, clr_cnt;
  logic [7:0] cnt_bcd;
  logic [7:0] led;
  logic [3:0] an;
  logic [7:0] seg;

  int checks = 0;
  int errors = 0;

  z_event_display #(.SCAN_DIV(4), .HIST_LEN(8)) dut (
    .CP      (CP),
    .rst     (rst),
    .y       (y),
    .Z       (Z),
    .clr_cnt (clr_cnt),
    .cnt_bcd (cnt_bcd),
    .led     (led),
    .an      (an),
    .seg     (seg)
  );

  always #5 CP = ~CP;

  // Inputs change and outputs are sampled 1 ns after each rising edge
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge CP);
      #1;
    end
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic pulse_z();
    Z = 1'b1;
    tick(2);
    Z = 1'b0;
    tick(2);
  endtask

  logic [3:0] exp_an  [4];
  logic [7:0] exp_seg [4];
  logic [3:0] prev_an;
  logic       found;

  initial begin
    rst = 1'b1; y = 1'b0; Z = 1'b0; clr_cnt = 1'b0;
    exp_an  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    exp_seg = '{8'h07, 8'h4F, 8'h06, 8'h00};

    // Reset state
    tick(2);
    check_output("rst_cnt", cnt_bcd, 8'h00);
    check_output("rst_led", led, 8'h00);
    check_output("rst_an", an, 4'b0001);
    check_output("rst_seg", seg, 8'h3F);
    rst = 1'b0;
    tick(4);
    check_output("scan_slot0_end_an", an, 4'b0001);
    tick(1);
    check_output("scan_slot1_an", an, 4'b0010);
    check_output("scan_slot1_seg", seg, 8'h3F);

    // First pulse: count changes exactly three edges after Z rises
    Z = 1'b1;
    tick(2);
    check_output("lat_2cyc", cnt_bcd, 8'h00);
    tick(1);
    check_output("lat_3cyc", cnt_bcd, 8'h01);
    Z = 1'b0;
    tick(1);
    for (int i = 0; i < 11; i++) pulse_z();
    tick(4);
    check_output("count_12", cnt_bcd, 8'h12);

    // Wrap 99 -> 00 after 100 pulses from zero
    clr_cnt = 1'b1;
    tick(1);
    clr_cnt = 1'b0;
    check_output("clr_to_00", cnt_bcd, 8'h00);
    for (int i = 0; i < 99; i++) pulse_z();
    check_output("count_99", cnt_bcd, 8'h99);
    Z = 1'b1;
    tick(2);
    check_output("wrap_before", cnt_bcd, 8'h99);
    tick(1);
    check_output("wrap_after", cnt_bcd, 8'h00);
    Z = 1'b0;
    tick(3);
    check_output("wrap_hold", cnt_bcd, 8'h00);

    // clr_cnt coincident with z_rise: result 00, edge dropped
    for (int i = 0; i < 5; i++) pulse_z();
    check_output("count_05", cnt_bcd, 8'h05);
    Z = 1'b1;
    tick(2);
    clr_cnt = 1'b1;
    tick(1);
    check_output("clr_prio", cnt_bcd, 8'h00);
    clr_cnt = 1'b0;
    tick(1);
    Z = 1'b0;
    tick(4);
    check_output("clr_hold", cnt_bcd, 8'h00);

    // y history
    y = 1'b1;
    tick(4);
    check_output("hist_1", led, 8'h01);
    y = 1'b0;
    tick(4);
    check_output("hist_10", led, 8'h02);
    y = 1'b1;
    tick(4);
    check_output("hist_101", led, 8'h05);
    tick(20);
    check_output("hist_stable", led, 8'h05);

    // Display scan with count 37 and y = 1
    for (int i = 0; i < 37; i++) pulse_z();
    check_output("count_37", cnt_bcd, 8'h37);
    found = 1'b0;
    for (int i = 0; i < 16 && !found; i++) begin
      prev_an = an;
      tick(1);
      if (prev_an == 4'b1000 && an == 4'b0001) found = 1'b1;
    end
    check_output("scan_sync", {31'd0, found}, 32'd1);
    for (int s = 0; s < 8; s++) begin
      for (int c = 0; c < 4; c++) begin
        check_output($sformatf("scan_an_s%0d_c%0d", s, c), an, exp_an[s % 4]);
        check_output($sformatf("scan_seg_s%0d_c%0d", s, c), seg, exp_seg[s % 4]);
        check_output("an_onehot", {31'd0, $onehot(an)}, 32'd1);
        tick(1);
      end
    end

    // Reset mid-scan returns to digit 0 showing '0'
    tick(6);
    rst = 1'b1;
    tick(1);
    check_output("midrst_an", an, 4'b0001);
    check_output("midrst_seg", seg, 8'h3F);
    check_output("midrst_cnt", cnt_bcd, 8'h00);
    check_output("midrst_led", led, 8'h00);
    rst = 1'b0;
    tick(3);
    check_output("midrst_slot0_an", an, 4'b0001);
    check_output("midrst_slot0_seg", seg, 8'h3F);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
